// File: rtl/fib_bcd_capture_pkg.sv
// fib_pkg: shared definitions for the Fibonacci result capture / BCD block.
//   - default bus width and BCD digit count
//   - FSM state encodings and the state enum built on them
package fib_pkg;

  localparam int DEF_BUS_WIDTH = 8;
  localparam int DEF_DIGITS    = 3;

  localparam logic [1:0] ST_IDLE_ENC    = 2'd0;
  localparam logic [1:0] ST_CONVERT_ENC = 2'd1;
  localparam logic [1:0] ST_HOLD_ENC    = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = ST_IDLE_ENC,
    ST_CONVERT = ST_CONVERT_ENC,
    ST_HOLD    = ST_HOLD_ENC
  } state_e;

endpackage

// File: rtl/fib_bcd_capture_if.sv
// fib_bcd_capture_if: valid/ready output channel carrying a finished BCD
// conversion and the index that produced it.
//   out_valid : producer holds a finished result
//   out_ready : consumer accepts when high together with out_valid
//   bcd       : packed BCD, digit 0 in bits [3:0]
//   n_tag     : index captured with the result
interface fib_bcd_capture_if
  import fib_pkg::*;
#(
  parameter int BUS_WIDTH = DEF_BUS_WIDTH,
  parameter int DIGITS    = DEF_DIGITS
);

  logic                   out_valid;
  logic                   out_ready;
  logic [4*DIGITS-1:0]    bcd;
  logic [BUS_WIDTH-1:0]   n_tag;

  modport master (output out_valid, output bcd, output n_tag, input out_ready);
  modport slave  (input out_valid, input bcd, input n_tag, output out_ready);

endinterface

// File: rtl/fib_bcd_capture_bcd_add3.sv
// bcd_add3: combinational double-dabble digit correction.
//   digit_i : one BCD digit before the shift
//   digit_o : digit_i + 3 when digit_i >= 5, otherwise digit_i
module bcd_add3 (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  // Pre-shift correction so the doubled digit carries into the next decade.
  always_comb begin
    digit_o = digit_i;
    if (digit_i >= 4'd5) begin
      digit_o = digit_i + 4'd3;
    end else begin
      digit_o = digit_i;
    end
  end

endmodule

// File: rtl/fib_bcd_capture.sv
// fib_bcd_capture: captures a Fibonacci result on the rising edge of Stop,
// converts it to packed BCD with a sequential shift-add-3 engine and offers it
// on a valid/ready channel. One conversion at a time; completions seen while
// busy are discarded and flagged on drop.
//   clock     : rising-edge clock
//   reset     : synchronous, active-low
//   Stop      : upstream done level, completion = 0->1 transition
//   fibonacci : upstream result
//   n         : index that produced the result
//   busy      : conversion in progress or result waiting for acceptance
//   drop      : single-cycle pulse when a completion edge is discarded
//   out_if    : result channel (out_valid/out_ready/bcd/n_tag)
module fib_bcd_capture
  import fib_pkg::*;
#(
  parameter int BUS_WIDTH = DEF_BUS_WIDTH,
  parameter int DIGITS    = DEF_DIGITS
)(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 Stop,
  input  logic [BUS_WIDTH-1:0] fibonacci,
  input  logic [BUS_WIDTH-1:0] n,
  output logic                 busy,
  output logic                 drop,
  fib_bcd_capture_if.master    out_if
);

  localparam int CNT_W = $clog2(BUS_WIDTH + 1);
  localparam int BCD_W = 4 * DIGITS;

  state_e               state_q, state_d;
  logic                 stop_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BUS_WIDTH-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d;
  logic [BUS_WIDTH-1:0] ntag_q, ntag_d;
  logic                 out_valid_q, out_valid_d;
  logic                 busy_q, busy_d;
  logic [BCD_W-1:0]     bcd_adj_s;
  logic                 stop_rise_s;
  logic                 drop_s;

  assign stop_rise_s = Stop & ~stop_q;

  // One add-3 corrector per BCD digit, all working on the current accumulator.
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit_i (bcd_q[4*g +: 4]),
      .digit_o (bcd_adj_s[4*g +: 4])
    );
  end

  // Next-state, datapath and output-register logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    ntag_d  = ntag_q;
    case (state_q)
      ST_IDLE: begin
        if (stop_rise_s) begin
          bin_d   = fibonacci;
          ntag_d  = n;
          bcd_d   = {BCD_W{1'b0}};
          cnt_d   = CNT_W'(BUS_WIDTH);
          state_d = ST_CONVERT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CONVERT: begin
        // Corrected digits and remaining binary shift together; binary MSB
        // enters the BCD LSB.
        {bcd_d, bin_d} = {bcd_adj_s, bin_q} << 1;
        cnt_d          = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_CONVERT;
        end
      end
      ST_HOLD: begin
        if (out_valid_q && out_if.out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    out_valid_d = (state_d == ST_HOLD);
    busy_d      = (state_d != ST_IDLE);
    // Any completion edge outside IDLE is lost, including the handshake cycle.
    drop_s      = stop_rise_s & (state_q != ST_IDLE);
  end

  // State, edge-detector and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      stop_q      <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
      bin_q       <= {BUS_WIDTH{1'b0}};
      bcd_q       <= {BCD_W{1'b0}};
      ntag_q      <= {BUS_WIDTH{1'b0}};
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      stop_q      <= Stop;
      cnt_q       <= cnt_d;
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      ntag_q      <= ntag_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign out_if.out_valid = out_valid_q;
  assign out_if.bcd       = bcd_q;
  assign out_if.n_tag     = ntag_q;
  assign busy             = busy_q;
  assign drop             = drop_s;

endmodule
